// File: rtl/wave_nco_core.sv
// DDS waveform core: phase accumulator + saw/triangle/square/sine shaper, optional LFSR noise (WAVE_NOISE_EN).
// Latency: wave_out/wave_valid register one cycle after the phase sample; config takes effect at a phase wrap.
// Backpressure: cfg_ready drops while a config is pending and returns after the wrap that applies it.
module wave_nco_core #(
    parameter int PHASE_W = 24,
    parameter int DATA_W  = 8,
    parameter int LUT_AW  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               phase_clr,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_fstep,
    input  logic [7:0]         cfg_duty,
    input  logic               cfg_noise,
    output logic [DATA_W-1:0]  wave_out,
    output logic               wave_valid,
    output logic               phase_wrap
);

    localparam int LUT_N = 1 << LUT_AW;
    localparam logic [DATA_W-1:0] HALF = {1'b1, {(DATA_W-1){1'b0}}};

    // Quarter-wave table, amplitude 2^(DATA_W-1)-1, rounded to nearest.
    function automatic logic [DATA_W-2:0] sine_entry(input int k);
        real amp;
        amp = real'((1 << (DATA_W-1)) - 1) * $sin(3.14159265358979323846 * k / (2.0 * LUT_N));
        return (DATA_W-1)'($rtoi(amp + 0.5));
    endfunction

    logic [DATA_W-2:0] lut [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut[k] = sine_entry(k);
    end

    logic [1:0]         mode, sh_mode;
    logic [PHASE_W-1:0] fstep, sh_fstep;
    logic [7:0]         duty, sh_duty;
    logic               noise, sh_noise;
    logic               pending;
    logic [PHASE_W-1:0] acc;

    logic [PHASE_W:0]   sum;
    logic [DATA_W-1:0]  p;
    logic               xfer;
    logic               wrap_evt;
    logic [DATA_W-1:0]  shape;
    logic [DATA_W-1:0]  sample;
    logic [1:0]         quad;
    logic [LUT_AW-1:0]  lut_idx;
    logic [DATA_W-2:0]  lut_val;

    assign sum      = {1'b0, acc} + {1'b0, fstep};
    assign p        = acc[PHASE_W-1 -: DATA_W];
    assign xfer     = cfg_valid && cfg_ready;
    assign wrap_evt = phase_clr || (ena && sum[PHASE_W]);
    assign quad     = p[DATA_W-1 -: 2];
    assign lut_idx  = p[DATA_W-3 -: LUT_AW];

    always_comb begin
        shape   = p;
        lut_val = quad[0] ? lut[~lut_idx] : lut[lut_idx];
        case (mode)
            2'd0: shape = p;
            2'd1: shape = p[DATA_W-1] ? {~p[DATA_W-2:0], 1'b0} : {p[DATA_W-2:0], 1'b0};
            2'd2: shape = {DATA_W{p[DATA_W-1 -: 8] < duty}};
            default: shape = quad[1] ? HALF - {1'b0, lut_val} : HALF + {1'b0, lut_val};
        endcase
    end

`ifdef WAVE_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else if (ena) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
        end
    end

    assign sample = shape ^ (noise ? DATA_W'(lfsr[3:0]) : {DATA_W{1'b0}});
`else
    logic unused_noise;
    assign unused_noise = noise;
    assign sample       = shape;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            mode       <= 2'd0;
            fstep      <= '0;
            duty       <= 8'h80;
            noise      <= 1'b0;
            sh_mode    <= 2'd0;
            sh_fstep   <= '0;
            sh_duty    <= 8'h80;
            sh_noise   <= 1'b0;
            pending    <= 1'b0;
            cfg_ready  <= 1'b1;
            wave_out   <= '0;
            wave_valid <= 1'b0;
            phase_wrap <= 1'b0;
        end else begin
            if (phase_clr) begin
                acc        <= '0;
                phase_wrap <= 1'b0;
            end else if (ena) begin
                acc        <= sum[PHASE_W-1:0];
                phase_wrap <= sum[PHASE_W];
            end else begin
                phase_wrap <= 1'b0;
            end

            wave_valid <= ena;
            if (ena) begin
                wave_out <= sample;
            end

            // A transfer implies nothing is pending, so it never collides with the wrap apply.
            if (xfer && ena) begin
                sh_mode   <= cfg_mode;
                sh_fstep  <= cfg_fstep;
                sh_duty   <= cfg_duty;
                sh_noise  <= cfg_noise;
                pending   <= 1'b1;
                cfg_ready <= 1'b0;
            end else if (xfer) begin
                mode  <= cfg_mode;
                fstep <= cfg_fstep;
                duty  <= cfg_duty;
                noise <= cfg_noise;
            end else if (wrap_evt && pending) begin
                mode      <= sh_mode;
                fstep     <= sh_fstep;
                duty      <= sh_duty;
                noise     <= sh_noise;
                pending   <= 1'b0;
                cfg_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wave_nco_core.sv
// Bench for wave_nco_core: shape-probe table, hand-written corner sequences, random run against a reference model.
module tb_wave_nco_core;

    logic        clk = 1'b0;
    logic        rst_n, ena, phase_clr, cfg_valid, cfg_noise;
    logic        cfg_ready, wave_valid, phase_wrap;
    logic [1:0]  cfg_mode;
    logic [23:0] cfg_fstep;
    logic [7:0]  cfg_duty;
    logic [7:0]  wave_out;

    always #5 clk = ~clk;

    wave_nco_core #(.PHASE_W(24), .DATA_W(8), .LUT_AW(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .phase_clr  (phase_clr),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_fstep  (cfg_fstep),
        .cfg_duty   (cfg_duty),
        .cfg_noise  (cfg_noise),
        .wave_out   (wave_out),
        .wave_valid (wave_valid),
        .phase_wrap (phase_wrap)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned m_acc, m_fstep, s_fstep;
    int          m_mode, m_duty, m_noise, s_mode, s_duty, s_noise;
    bit          m_pend;
    int          m_out;
    bit          m_vld, m_wrap;
    int          m_lfsr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lut(input int k);
        return $rtoi(127.0 * $sin(3.14159265358979323846 * k / 128.0) + 0.5);
    endfunction

    function automatic int shape(input int mode, input int p, input int duty);
        int q, i;
        q = p / 64;
        i = p % 64;
        case (mode)
            0: return p;
            1: return (p < 128) ? 2 * p : 2 * (255 - p);
            2: return (p < duty) ? 255 : 0;
            default: begin
                case (q)
                    0: return 128 + lut(i);
                    1: return 128 + lut(63 - i);
                    2: return 128 - lut(i);
                    default: return 128 - lut(63 - i);
                endcase
            end
        endcase
    endfunction

    task automatic model_update();
        longint sum;
        bit     wev;
        bit     xfer;
        if (!rst_n) begin
            m_acc = 0; m_mode = 0; m_fstep = 0; m_duty = 'h80; m_noise = 0;
            m_pend = 0; m_out = 0; m_vld = 0; m_wrap = 0; m_lfsr = 'hACE1;
        end else begin
            xfer = cfg_valid && !m_pend;
            if (ena) begin
                m_out = shape(m_mode, int'(m_acc >> 16), m_duty);
`ifdef WAVE_NOISE_EN
                if (m_noise != 0) m_out = m_out ^ (m_lfsr & 15);
                m_lfsr = ((m_lfsr & 1) != 0) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
`endif
            end
            m_vld = ena;
            wev = 0;
            if (phase_clr) begin
                m_acc = 0; m_wrap = 0; wev = 1;
            end else if (ena) begin
                sum    = longint'(m_acc) + longint'(m_fstep);
                m_wrap = (sum >= 64'd16777216);
                m_acc  = 32'(sum % 64'd16777216);
                wev    = m_wrap;
            end else begin
                m_wrap = 0;
            end
            if (wev && m_pend) begin
                m_mode = s_mode; m_fstep = s_fstep; m_duty = s_duty; m_noise = s_noise;
                m_pend = 0;
            end
            if (xfer) begin
                if (ena) begin
                    s_mode = int'(cfg_mode); s_fstep = 32'(cfg_fstep);
                    s_duty = int'(cfg_duty); s_noise = int'(cfg_noise);
                    m_pend = 1;
                end else begin
                    m_mode = int'(cfg_mode); m_fstep = 32'(cfg_fstep);
                    m_duty = int'(cfg_duty); m_noise = int'(cfg_noise);
                end
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("wave_out", 32'(wave_out), 32'(m_out));
        check("wave_valid", 32'(wave_valid), 32'(m_vld));
        check("phase_wrap", 32'(phase_wrap), 32'(m_wrap));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    endtask

    task automatic set_in(input bit r, input bit e, input bit c, input bit v,
                          input int mode, input int unsigned fs, input int duty, input bit nz);
        rst_n = r; ena = e; phase_clr = c; cfg_valid = v;
        cfg_mode = 2'(mode); cfg_fstep = 24'(fs); cfg_duty = 8'(duty); cfg_noise = nz;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic load_idle(input int mode, input int unsigned fs, input int duty, input bit nz);
        set_in(1, 0, 0, 1, mode, fs, duty, nz);
        step();
        cfg_valid = 0;
    endtask

    typedef struct {
        string name;
        int    mode;
        int    duty;
        int    p;
        int    exp;
    } vec_t;

    vec_t tbl[20];
    int   nv = 0;

    task automatic add_vec(input string n, input int mode, input int duty, input int p, input int e);
        tbl[nv].name = n; tbl[nv].mode = mode; tbl[nv].duty = duty; tbl[nv].p = p; tbl[nv].exp = e;
        nv++;
    endtask

    initial begin
        int errs, wraps, wrap_at;

        add_vec("saw_p0",     0, 'h80, 0,   0);
        add_vec("saw_p100",   0, 'h80, 100, 100);
        add_vec("saw_p255",   0, 'h80, 255, 255);
        add_vec("tri_p1",     1, 'h80, 1,   2);
        add_vec("tri_p127",   1, 'h80, 127, 254);
        add_vec("tri_p128",   1, 'h80, 128, 254);
        add_vec("tri_p200",   1, 'h80, 200, 110);
        add_vec("tri_p255",   1, 'h80, 255, 0);
        add_vec("sq40_p63",   2, 'h40, 63,  255);
        add_vec("sq40_p64",   2, 'h40, 64,  0);
        add_vec("sq00_p0",    2, 'h00, 0,   0);
        add_vec("sqff_p254",  2, 'hFF, 254, 255);
        add_vec("sqff_p255",  2, 'hFF, 255, 0);
        add_vec("sin_p0",     3, 'h80, 0,   'h80);
        add_vec("sin_p32",    3, 'h80, 32,  'hDA);
        add_vec("sin_p64",    3, 'h80, 64,  'hFF);
        add_vec("sin_p128",   3, 'h80, 128, 'h80);
        add_vec("sin_p192",   3, 'h80, 192, 'h01);

        do_reset();
        check("rst_wave_out", 32'(wave_out), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 1);

        // Shape probes: load fstep=p<<16, two enabled cycles put shape(p) on wave_out
        for (int i = 0; i < nv; i++) begin
            do_reset();
            load_idle(tbl[i].mode, 32'(tbl[i].p) << 16, tbl[i].duty, 0);
            ena = 1;
            step();
            step();
            check(tbl[i].name, 32'(wave_out), 32'(tbl[i].exp));
        end

        // Full saw period with wrap pulse
        do_reset();
        load_idle(0, 'h010000, 'h80, 0);
        ena = 1;
        errs = 0; wraps = 0; wrap_at = -1;
        for (int i = 0; i <= 256; i++) begin
            step();
            if (32'(wave_out) != 32'(i % 256)) errs++;
            if (phase_wrap) begin wraps++; wrap_at = i; end
        end
        check("saw_ramp", 32'(errs), 0);
        check("saw_wrap_count", 32'(wraps), 1);
        check("saw_wrap_at", 32'(wrap_at), 255);

        // Handshake: offer at p=100, second offer stalls until wrap
        do_reset();
        load_idle(0, 'h010000, 'h80, 0);
        ena = 1;
        for (int i = 0; i < 100; i++) step();
        set_in(1, 1, 0, 1, 3, 'h010000, 'h80, 0);
        step();
        check("hs_ready_fall", 32'(cfg_ready), 0);
        cfg_mode = 2'd1;
        errs = 0;
        for (int k = 101; k <= 255; k++) begin
            step();
            if (k < 255 && cfg_ready !== 1'b0) errs++;
        end
        check("hs_stall", 32'(errs), 0);
        check("hs_saw_end", 32'(wave_out), 255);
        check("hs_ready_back", 32'(cfg_ready), 1);
        step();
        check("hs_sine_start", 32'(wave_out), 'h80);
        check("hs_second_taken", 32'(cfg_ready), 0);
        cfg_valid = 0;
        step();

        // Reset while a config is pending
        do_reset();
        check("rstp_wave_out", 32'(wave_out), 0);
        check("rstp_valid", 32'(wave_valid), 0);
        check("rstp_wrap", 32'(phase_wrap), 0);
        check("rstp_ready", 32'(cfg_ready), 1);
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        check("rstp_discard", 32'(wave_out), 0);

        // phase_clr at p=50
        do_reset();
        load_idle(0, 'h010000, 'h80, 0);
        ena = 1;
        for (int i = 0; i < 50; i++) step();
        phase_clr = 1;
        step();
        check("clr_out_p50", 32'(wave_out), 50);
        check("clr_no_wrap", 32'(phase_wrap), 0);
        phase_clr = 0;
        step();
        check("clr_p0", 32'(wave_out), 0);

`ifdef WAVE_NOISE_EN
        do_reset();
        load_idle(0, 0, 'h80, 1);
        ena = 1;
        step();
        check("noise_s0", 32'(wave_out), 1);
        step();
        check("noise_s1", 32'(wave_out), 0);
        step();
        check("noise_s2", 32'(wave_out), 8);
`endif

        // Random run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 199) != 0,
                   $urandom_range(0, 7) != 0,
                   $urandom_range(0, 63) == 0,
                   $urandom_range(0, 11) == 0,
                   int'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFFFF) : ($urandom & 32'h0FFFFF),
                   int'($urandom_range(0, 255)),
                   $urandom_range(0, 1) == 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_nco_core.md
Name: wave_nco_core

Overview:
- Parametrised DDS waveform core: phase accumulator plus shape stage producing saw, triangle, square (programmable duty) and sine, with optional LFSR noise mixing.
- Successor to the fixed 8-bit waveform engine behind the UART command decoder.
- The decoder drives the config handshake; wave_out feeds the output pins or DAC.
- Config changes are glitch-free: applied only at a phase wrap.

Parameters:
- PHASE_W, 24, accumulator width; must be >= DATA_W.
- DATA_W, 8, output sample width (unsigned, offset binary).
- LUT_AW, 6, quarter-sine table address bits; must be <= DATA_W-2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  advance enable; accumulator holds when low.
- phase_clr  in  1  synchronous accumulator clear.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept.
- cfg_mode  in  2  0 saw, 1 triangle, 2 square, 3 sine.
- cfg_fstep  in  PHASE_W  phase increment.
- cfg_duty  in  8  square high threshold.
- cfg_noise  in  1  noise mix enable.
- wave_out  out  DATA_W  sample.
- wave_valid  out  1  registered ena.
- phase_wrap  out  1  one-cycle pulse on accumulator overflow.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - acc=0, active cfg = mode 0 / fstep 0 / duty 8'h80 / noise 0.
  - pending=0, cfg_ready=1.
  - wave_out=0, wave_valid=0, phase_wrap=0.
  - LFSR=16'hACE1.
  - Reset mid-operation also drops any pending config.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready. Fields latch into a shadow register and pending=1.
  - cfg_ready = !pending (registered).
  - A transfer while ena=0 applies directly to the active cfg on that edge; pending stays 0.
- Pending apply: on the edge where the accumulator wraps, the shadow loads into active and pending clears. The new fstep is used from the next increment onward.
- Accumulator:
  - When ena=1: acc <= acc + fstep (mod 2^PHASE_W).
  - phase_wrap <= carry-out.
  - phase_clr has priority: acc <= 0, counts as a wrap (applies pending), and phase_wrap=0.
- Latency: p = acc[PHASE_W-1 -: DATA_W] of the current register value; wave_out and wave_valid register one cycle later.
- Shapes (M = DATA_W-bit max):
  - Saw: p.
  - Triangle:
    - p MSB=0: {p[DATA_W-2:0],0}.
    - p MSB=1: {~p[DATA_W-2:0],0}.
  - Square: M when p[DATA_W-1 -: 8] < duty, else 0.
    - duty=0: constant 0.
    - duty=8'hFF: low 1/256 of the period.
  - Sine:
    - q = p top 2 bits; i = next LUT_AW bits.
    - lut[k] = round((2^(DATA_W-1)-1)*sin(pi/2*k/2^LUT_AW)).
    - q0: H+lut[i]; q1: H+lut[N-1-i]; q2: H-lut[i]; q3: H-lut[N-1-i], where H=2^(DATA_W-1) and N=2^LUT_AW.
- wave_out holds its value while ena=0.

Optional Feature:
- Macro WAVE_NOISE_EN.
- When defined:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, steps every cycle ena=1.
  - With active noise=1, wave_out = shape XOR {lfsr[3:0]} aligned to the sample LSBs (zero-extended to DATA_W).
- When undefined:
  - No LFSR; cfg_noise is accepted but ignored.
  - wave_out is the pure shape.

Test Plan:
1. Saw: rst, ena=0, load mode 0, fstep 24'h010000; ena=1 -> wave_out 0,1,2..255,0; phase_wrap pulses every 256 cycles.
2. Triangle: same fstep, mode 1 -> 0,2..254, then 254,252..0.
3. Square: mode 2, duty 8'h40, fstep 24'h010000 -> 64 cycles of 8'hFF, then 192 cycles of 8'h00, repeating.
4. Sine: mode 3, fstep 24'h010000 -> wave_out 8'h80 at p=0, 8'hFF at p=64, 8'h80 at p=128, 8'h01 at p=192.
5. Handshake: running saw, offer mode 3 at p=100 -> cfg_ready falls the next cycle. A second offer stalls until the wrap. Saw continues to 255, then the sine starts. cfg_ready returns high after the wrap.
6. Reset/clear:
   - rst_n=0 mid-period with a pending config -> all outputs 0, cfg_ready=1, pending discarded.
   - phase_clr at p=50 -> next p=0 with no phase_wrap pulse.
   - Under WAVE_NOISE_EN, noise=1 -> the first post-reset LSBs follow LFSR seed 16'hACE1.
